// File: rtl/brcomp_pipe.sv
// Branch-resolution unit: decodes B-type funct3, compares rs1/rs2,
// registers the outcome in a one-entry valid/ready pipeline register,
// flags mispredictions and keeps saturating resolved/mispredict counters.
module brcomp_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [XLEN-1:0]  rs1_data_i,
    input  logic [XLEN-1:0]  rs2_data_i,
    input  logic [2:0]       br_func_i,
    input  logic             pred_taken_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             br_taken_o,
    output logic             br_equal_o,
    output logic             br_less_o,
    output logic             mispredict_o,
    output logic             illegal_o,
    output logic [TAG_W-1:0] tag_o,
    input  logic             cnt_clear_i,
    output logic [CNT_W-1:0] cnt_branch_o,
    output logic [CNT_W-1:0] cnt_mispred_o
);

    localparam logic [2:0] F_BEQ  = 3'b000;
    localparam logic [2:0] F_BNE  = 3'b001;
    localparam logic [2:0] F_BLT  = 3'b100;
    localparam logic [2:0] F_BGE  = 3'b101;
    localparam logic [2:0] F_BLTU = 3'b110;
    localparam logic [2:0] F_BGEU = 3'b111;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic cmp_eq;
    logic cmp_lt_s;
    logic cmp_lt_u;
    logic cmp_lt;
    logic dec_taken;
    logic dec_illegal;
    logic dec_mispred;
    logic in_accept;
    logic out_hs;
    logic cnt_event;

    // Input-side comparison; funct3[1] selects unsigned ordering.
    always_comb begin
        cmp_eq   = (rs1_data_i == rs2_data_i);
        cmp_lt_s = ($signed(rs1_data_i) < $signed(rs2_data_i));
        cmp_lt_u = (rs1_data_i < rs2_data_i);
        cmp_lt   = br_func_i[1] ? cmp_lt_u : cmp_lt_s;
    end

    // funct3 decode to direction; 010/011 are not branches.
    always_comb begin
        dec_taken   = 1'b0;
        dec_illegal = 1'b0;
        unique case (br_func_i)
            F_BEQ:          dec_taken = cmp_eq;
            F_BNE:          dec_taken = !cmp_eq;
            F_BLT, F_BLTU:  dec_taken = cmp_lt;
            F_BGE, F_BGEU:  dec_taken = !cmp_lt;
            default:        dec_illegal = 1'b1;
        endcase
        dec_mispred = !dec_illegal && (dec_taken != pred_taken_i);
    end

    // Handshake qualifiers; in_ready never looks at in_valid.
    always_comb begin
        in_ready_o = !flush_i && (!out_valid_o || out_ready_i);
        in_accept  = in_valid_i && in_ready_o;
        out_hs     = out_valid_o && out_ready_i;
        cnt_event  = out_hs && !illegal_o;
    end

    // Result register: reload on accept, drop on handshake or flush.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_valid_o  <= 1'b0;
            br_taken_o   <= 1'b0;
            br_equal_o   <= 1'b0;
            br_less_o    <= 1'b0;
            mispredict_o <= 1'b0;
            illegal_o    <= 1'b0;
            tag_o        <= '0;
        end else if (in_accept) begin
            out_valid_o  <= 1'b1;
            br_taken_o   <= dec_taken;
            br_equal_o   <= cmp_eq;
            br_less_o    <= cmp_lt;
            mispredict_o <= dec_mispred;
            illegal_o    <= dec_illegal;
            tag_o        <= tag_i;
        end else if (out_hs || flush_i) begin
            out_valid_o  <= 1'b0;
        end
    end

    // Saturating statistics; clear wins over a same-cycle increment.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_branch_o  <= '0;
            cnt_mispred_o <= '0;
        end else if (cnt_clear_i) begin
            cnt_branch_o  <= '0;
            cnt_mispred_o <= '0;
        end else if (cnt_event) begin
            if (cnt_branch_o != CNT_MAX) begin
                cnt_branch_o <= cnt_branch_o + 1'b1;
            end
            if (mispredict_o && (cnt_mispred_o != CNT_MAX)) begin
                cnt_mispred_o <= cnt_mispred_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_brcomp_pipe.sv
// Bench for brcomp_pipe: directed scenarios plus random traffic, checked
// against a transaction-level reference model of the result register.
module tb_brcomp_pipe;

    localparam int XLEN  = 32;
    localparam int TAG_W = 32;
    localparam int CNT_W = 2;
    localparam int CMAX  = 3;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [XLEN-1:0]  rs1_data_i;
    logic [XLEN-1:0]  rs2_data_i;
    logic [2:0]       br_func_i;
    logic             pred_taken_i;
    logic [TAG_W-1:0] tag_i;
    logic             flush_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic             br_taken_o;
    logic             br_equal_o;
    logic             br_less_o;
    logic             mispredict_o;
    logic             illegal_o;
    logic [TAG_W-1:0] tag_o;
    logic             cnt_clear_i;
    logic [CNT_W-1:0] cnt_branch_o;
    logic [CNT_W-1:0] cnt_mispred_o;

    brcomp_pipe #(.XLEN(XLEN), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .br_func_i(br_func_i), .pred_taken_i(pred_taken_i), .tag_i(tag_i),
        .flush_i(flush_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .br_taken_o(br_taken_o), .br_equal_o(br_equal_o), .br_less_o(br_less_o),
        .mispredict_o(mispredict_o), .illegal_o(illegal_o), .tag_o(tag_o),
        .cnt_clear_i(cnt_clear_i), .cnt_branch_o(cnt_branch_o),
        .cnt_mispred_o(cnt_mispred_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: what the output register should hold.
    logic        m_valid, m_taken, m_eq, m_less, m_mis, m_ill;
    logic [31:0] m_tag;
    int          m_cb, m_cm;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Branch semantics from the ISA rules using plain integer arithmetic.
    function automatic void ref_branch(input logic [31:0] a, input logic [31:0] b,
                                       input logic [2:0] f, input logic p,
                                       output logic t, output logic e, output logic l,
                                       output logic m, output logic il);
        longint sa, sb;
        sa = a[31] ? longint'(a) - 64'sd4294967296 : longint'(a);
        sb = b[31] ? longint'(b) - 64'sd4294967296 : longint'(b);
        e  = (longint'(a) == longint'(b));
        l  = f[1] ? (longint'(a) < longint'(b)) : (sa < sb);
        il = 1'b0;
        t  = 1'b0;
        case (f)
            3'd0: t = e;
            3'd1: t = !e;
            3'd4, 3'd6: t = l;
            3'd5, 3'd7: t = !l;
            default: il = 1'b1;
        endcase
        m = !il && (t != p);
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".valid"},   64'(out_valid_o),   64'(m_valid));
        chk({tag, ".taken"},   64'(br_taken_o),    64'(m_taken));
        chk({tag, ".equal"},   64'(br_equal_o),    64'(m_eq));
        chk({tag, ".less"},    64'(br_less_o),     64'(m_less));
        chk({tag, ".mispred"}, 64'(mispredict_o),  64'(m_mis));
        chk({tag, ".illegal"}, 64'(illegal_o),     64'(m_ill));
        chk({tag, ".tag"},     64'(tag_o),         64'(m_tag));
        chk({tag, ".cnt_br"},  64'(cnt_branch_o),  64'(m_cb));
        chk({tag, ".cnt_mp"},  64'(cnt_mispred_o), 64'(m_cm));
    endtask

    // One clock: drive inputs, check in_ready, advance model, check outputs.
    task automatic step(input string tag, input logic rst, input logic v,
                        input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                        input logic p, input logic [31:0] t, input logic rdy,
                        input logic fl, input logic clr);
        logic exp_ready, acc, hs;
        logic rt, re, rl, rm, ril;
        rst_ni = rst; in_valid_i = v; rs1_data_i = a; rs2_data_i = b;
        br_func_i = f; pred_taken_i = p; tag_i = t; out_ready_i = rdy;
        flush_i = fl; cnt_clear_i = clr;
        #1;
        exp_ready = !fl && (!m_valid || rdy);
        chk({tag, ".in_ready"}, 64'(in_ready_o), 64'(exp_ready));
        acc = v && exp_ready;
        hs  = m_valid && rdy;
        ref_branch(a, b, f, p, rt, re, rl, rm, ril);
        if (!rst) begin
            m_valid = 0; m_taken = 0; m_eq = 0; m_less = 0; m_mis = 0; m_ill = 0;
            m_tag = 0; m_cb = 0; m_cm = 0;
        end else begin
            if (clr) begin
                m_cb = 0; m_cm = 0;
            end else if (hs && !m_ill) begin
                if (m_cb < CMAX) m_cb++;
                if (m_mis && m_cm < CMAX) m_cm++;
            end
            if (acc) begin
                m_valid = 1; m_taken = rt; m_eq = re; m_less = rl; m_mis = rm;
                m_ill = ril; m_tag = t;
            end else if (hs || fl) begin
                m_valid = 0;
            end
        end
        @(posedge clk_i);
        #1;
        check_all(tag);
    endtask

    logic [2:0]  t1_func [6];
    logic        t1_taken[6];
    logic [31:0] held_tag;
    logic        held_taken;

    initial begin
        m_valid = 0; m_taken = 0; m_eq = 0; m_less = 0; m_mis = 0; m_ill = 0;
        m_tag = 0; m_cb = 0; m_cm = 0;
        rst_ni = 0; in_valid_i = 0; rs1_data_i = 0; rs2_data_i = 0; br_func_i = 0;
        pred_taken_i = 0; tag_i = 0; out_ready_i = 0; flush_i = 0; cnt_clear_i = 0;
        @(posedge clk_i); #1;

        // Reset
        step("rst", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("rst2", 0, 1, 32'h5, 32'h5, 3'b000, 0, 32'h77, 1, 0, 0);

        // Per-function decode on 0xFFFFFFFF vs 1
        t1_func  = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b000, 3'b001};
        t1_taken = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            step($sformatf("dec%0d", i), 1, 1, 32'hFFFF_FFFF, 32'h1, t1_func[i], 0,
                 32'h100 + i, 1, 0, 0);
            chk($sformatf("dec%0d.lit_taken", i), 64'(br_taken_o), 64'(t1_taken[i]));
            if (i == 0) chk("dec_blt.lit_less", 64'(br_less_o), 64'd1);
            if (i == 1) chk("dec_bltu.lit_less", 64'(br_less_o), 64'd0);
        end

        // Misprediction counting
        step("mp_clr", 1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        step("mp_beq", 1, 1, 32'd5, 32'd5, 3'b000, 0, 32'h200, 1, 0, 0);
        chk("mp_beq.lit_mis", 64'(mispredict_o), 64'd1);
        step("mp_bne", 1, 1, 32'd5, 32'd5, 3'b001, 1, 32'h201, 1, 0, 0);
        chk("mp_bne.lit_mis", 64'(mispredict_o), 64'd1);
        step("mp_drain", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("mp.lit_cnt_br", 64'(cnt_branch_o), 64'd2);
        chk("mp.lit_cnt_mp", 64'(cnt_mispred_o), 64'd2);

        // Back-pressure
        step("bp_load", 1, 1, 32'd3, 32'd9, 3'b100, 0, 32'h300, 0, 0, 0);
        held_tag = tag_o; held_taken = br_taken_o;
        for (int i = 0; i < 3; i++) begin
            step($sformatf("bp_hold%0d", i), 1, 1, 32'd9, 32'd3, 3'b100, 1,
                 32'h310 + i, 0, 0, 0);
            chk($sformatf("bp_hold%0d.lit_tag", i), 64'(tag_o), 64'(held_tag));
            chk($sformatf("bp_hold%0d.lit_taken", i), 64'(br_taken_o), 64'(held_taken));
        end
        step("bp_release", 1, 1, 32'd9, 32'd3, 3'b101, 1, 32'h320, 1, 0, 0);
        chk("bp_release.lit_tag", 64'(tag_o), 64'h320);
        chk("bp_release.lit_valid", 64'(out_valid_o), 64'd1);

        // Flush with a held result and a competing input
        step("fl_load", 1, 1, 32'd1, 32'd2, 3'b000, 0, 32'h400, 0, 0, 0);
        step("fl", 1, 1, 32'd1, 32'd1, 3'b000, 0, 32'h401, 0, 1, 0);
        chk("fl.lit_valid", 64'(out_valid_o), 64'd0);

        // Illegal encoding
        step("ill", 1, 1, 32'd7, 32'd7, 3'b010, 1, 32'h500, 1, 0, 0);
        chk("ill.lit_illegal", 64'(illegal_o), 64'd1);
        chk("ill.lit_taken", 64'(br_taken_o), 64'd0);
        step("ill_drain", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // Saturation and clear priority
        step("sat_clr", 1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 5; i++)
            step($sformatf("sat%0d", i), 1, 1, 32'(i), 32'd2, 3'b110, 0, 32'h600 + i, 1, 0, 0);
        step("sat_drain", 1, 1, 32'd1, 32'd1, 3'b000, 0, 32'h610, 1, 0, 0);
        chk("sat.lit_cnt_br", 64'(cnt_branch_o), 64'd3);
        step("sat_clr_hs", 1, 1, 32'd1, 32'd1, 3'b000, 1, 32'h611, 1, 0, 1);
        chk("sat_clr_hs.lit_cnt_br", 64'(cnt_branch_o), 64'd0);
        chk("sat_clr_hs.lit_cnt_mp", 64'(cnt_mispred_o), 64'd0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            if ($urandom_range(0, 3) == 0) rb = {ra[31:1], ~ra[0]};
            step($sformatf("rnd%0d", i), 1, 1'($urandom_range(0, 3) != 0), ra, rb,
                 3'($urandom_range(0, 7)), 1'($urandom), $urandom,
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 31) == 0));
        end

        // Reset mid-operation
        step("mr_load0", 1, 1, 32'd4, 32'd4, 3'b000, 1, 32'h700, 1, 0, 0);
        step("mr_load1", 1, 1, 32'd4, 32'd4, 3'b001, 1, 32'h701, 1, 0, 0);
        chk("mr.pre_valid", 64'(out_valid_o), 64'd1);
        step("mr_rst", 0, 1, 32'd4, 32'd4, 3'b000, 0, 32'h702, 0, 0, 0);
        chk("mr.lit_valid", 64'(out_valid_o), 64'd0);
        chk("mr.lit_tag", 64'(tag_o), 64'd0);
        chk("mr.lit_cnt_br", 64'(cnt_branch_o), 64'd0);
        rst_ni = 1; in_valid_i = 0; out_ready_i = 0; flush_i = 0; #1;
        chk("mr.lit_in_ready", 64'(in_ready_o), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/brcomp_pipe.md
# brcomp_pipe

Pipelined, parametrised branch-resolution unit for the RISC-V core's execute stage. It decodes the B-type `funct3` directly, registers the comparison result behind a valid/ready handshake, and checks the outcome against the front-end prediction. It also keeps saturating counters of resolved branches and mispredictions for performance monitoring.

## Interface
Parameters:
- `XLEN`, 32: operand width in bits, ≥ 2.
- `TAG_W`, 32: width of the PC/ROB tag carried alongside the operands.
- `CNT_W`, 16: width of each statistics counter.

Ports:
- `clk_i`, in, 1: clock. The block uses a single clock domain.
- `rst_ni`, in, 1: reset. Synchronous and active-low.
- `in_valid_i`, in, 1: operands valid.
- `in_ready_o`, out, 1: block can accept operands.
- `rs1_data_i`, in, `XLEN`: operand A.
- `rs2_data_i`, in, `XLEN`: operand B.
- `br_func_i`, in, 3: B-type `funct3`.
- `pred_taken_i`, in, 1: front-end prediction.
- `tag_i`, in, `TAG_W`: instruction tag.
- `flush_i`, in, 1: pipeline flush.
- `out_valid_o`, out, 1: result valid.
- `out_ready_i`, in, 1: consumer accepts the result.
- `br_taken_o`, out, 1: resolved direction.
- `br_equal_o`, out, 1: rs1 == rs2.
- `br_less_o`, out, 1: rs1 < rs2, signed or unsigned according to `br_func_i[1]`.
- `mispredict_o`, out, 1: `br_taken_o` differs from the stored prediction.
- `illegal_o`, out, 1: `funct3` encoding is not a branch.
- `tag_o`, out, `TAG_W`: tag of the result.
- `cnt_clear_i`, in, 1: clear both counters.
- `cnt_branch_o`, out, `CNT_W`: resolved legal branches.
- `cnt_mispred_o`, out, `CNT_W`: mispredicted legal branches.

## Operation
- **Comparison.** The block computes the comparison combinationally on the input side.
  - `eq` = (rs1 == rs2).
  - `lt` is a signed compare when `br_func_i[1]` = 0 and an unsigned compare when it is 1.
- **Decode of `br_func_i`.**
  - 000 BEQ: taken = eq.
  - 001 BNE: taken = !eq.
  - 100 BLT: taken = lt (signed).
  - 101 BGE: taken = !lt (signed).
  - 110 BLTU: taken = lt (unsigned).
  - 111 BGEU: taken = !lt (unsigned).
  - 010 and 011: illegal. taken = 0, `mispredict_o` = 0, `illegal_o` = 1.
- **Output register.** The block has a single output register stage, so it is a one-entry pipeline register.
  - `in_ready_o` = !flush_i && (!out_valid_o || out_ready_i).
  - Input accept: `in_valid_i` && `in_ready_o` loads all result fields and sets `out_valid_o`.
  - Output handshake: `out_valid_o` && `out_ready_i`. With no accept in the same cycle, `out_valid_o` clears. With an accept in the same cycle, the register reloads.
  - Holding: while `out_valid_o` = 1 and `out_ready_i` = 0, every output field holds stable.
- **Flush.**
  - `flush_i` = 1 makes `out_valid_o` = 0 on the next cycle.
  - No input is accepted in a flush cycle.
  - An output handshake occurring in the flush cycle still completes and is counted.
- **Counters.**
  - Update occurs on an output handshake with `illegal_o` = 0. `cnt_branch_o` increments; `cnt_mispred_o` also increments if `mispredict_o` = 1.
  - Both counters saturate at 2^`CNT_W`−1.
  - `cnt_clear_i` zeroes both counters and has priority over a simultaneous increment.
- **Reset** (`rst_ni` = 0 at a rising edge):
  - `out_valid_o` = 0 and the counters = 0.
  - The data outputs (`br_taken_o`, `br_equal_o`, `br_less_o`, `mispredict_o`, `illegal_o`, `tag_o`) = 0.
  - `in_ready_o` = 1 after reset (combinational, with `flush_i` = 0).
  - A reset mid-operation discards any held result without a handshake.

## Timing
- **Latency:** 1 cycle. Operands accepted at edge N appear on the outputs after edge N and remain until handshaken.
- **Throughput:** 1 result per cycle while `out_ready_i` = 1.
- **Back-pressure:** `in_ready_o` depends combinationally on `out_ready_i` and `flush_i`. There is no path from `in_valid_i` to `in_ready_o`.
- **Counters:** values are registered and update on the edge that completes the output handshake.

## Test plan
1. **Per-function decode**, with `XLEN`=32 and rs1 = 0xFFFFFFFF, rs2 = 0x00000001, applying BLT, BLTU, BGE, BGEU, BEQ, BNE with `out_ready_i` = 1:
   - Required `br_taken_o`, one cycle later each: 1, 0, 0, 1, 0, 1.
   - Required `br_less_o` for the signed/unsigned pair: 1 for BLT, 0 for BLTU.
2. **Misprediction count:** BEQ 5,5 with `pred_taken_i`=0, then BNE 5,5 with `pred_taken_i`=1.
   - Required `mispredict_o`: 1, then 1.
   - After both handshakes: `cnt_branch_o` = 2, `cnt_mispred_o` = 2.
3. **Back-pressure:** hold `out_ready_i` = 0 for 3 cycles with a result held.
   - Required: `in_ready_o` = 0; `tag_o` and `br_taken_o` stay constant.
   - Then raise `out_ready_i` together with a new valid input. Required: the new result appears next cycle, with no bubble.
4. **Flush and illegal encoding.**
   - Flush: with a result held, assert `flush_i` and `in_valid_i` in the same cycle. Required: `out_valid_o` = 0 next cycle, the input is not accepted, and the counters are unchanged.
   - Illegal: apply `funct3` = 010. Required: `illegal_o` = 1, `br_taken_o` = 0, and the counters do not increment.
5. **Saturation and clear**, with `CNT_W`=2:
   - 5 legal handshakes. Required: `cnt_branch_o` = 3.
   - Assert `cnt_clear_i` during a legal handshake. Required: both counters = 0.
6. **Reset mid-operation:** drive `rst_ni` = 0 with `out_valid_o` = 1 and the counters nonzero.
   - Required next cycle: all outputs = 0 except `in_ready_o` = 1.
